// File: rtl/f_function_pipe.sv
// DES round function f(R,K) = P(S(E(R) ^ K)) as a valid/ready pipeline. Latency 2 cycles,
// or 3 with FFUNC_MID_REG_EN (S-box register); one result per cycle; a stalled output freezes upstream.

// Each S-box table is 64 nibbles, row-major (index = row*16 + col), with entry 0 in the top nibble.
module sbox1 (
  input  logic [5:0] idx_i,
  output logic [3:0] q_o
);
  localparam logic [255:0] TBL = {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
                                  64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D};
  logic [5:0] addr;
  assign addr = {idx_i[5], idx_i[0], idx_i[4:1]};
  assign q_o  = TBL[{~addr, 2'b11} -: 4];
endmodule

module sbox2 (
  input  logic [5:0] idx_i,
  output logic [3:0] q_o
);
  localparam logic [255:0] TBL = {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
                                  64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9};
  logic [5:0] addr;
  assign addr = {idx_i[5], idx_i[0], idx_i[4:1]};
  assign q_o  = TBL[{~addr, 2'b11} -: 4];
endmodule

module sbox3 (
  input  logic [5:0] idx_i,
  output logic [3:0] q_o
);
  localparam logic [255:0] TBL = {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
                                  64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C};
  logic [5:0] addr;
  assign addr = {idx_i[5], idx_i[0], idx_i[4:1]};
  assign q_o  = TBL[{~addr, 2'b11} -: 4];
endmodule

module sbox4 (
  input  logic [5:0] idx_i,
  output logic [3:0] q_o
);
  localparam logic [255:0] TBL = {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
                                  64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E};
  logic [5:0] addr;
  assign addr = {idx_i[5], idx_i[0], idx_i[4:1]};
  assign q_o  = TBL[{~addr, 2'b11} -: 4];
endmodule

module sbox5 (
  input  logic [5:0] idx_i,
  output logic [3:0] q_o
);
  localparam logic [255:0] TBL = {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
                                  64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};
  logic [5:0] addr;
  assign addr = {idx_i[5], idx_i[0], idx_i[4:1]};
  assign q_o  = TBL[{~addr, 2'b11} -: 4];
endmodule

module sbox6 (
  input  logic [5:0] idx_i,
  output logic [3:0] q_o
);
  localparam logic [255:0] TBL = {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
                                  64'h9EF528C3704A1DB6, 64'h432C95FABE17608D};
  logic [5:0] addr;
  assign addr = {idx_i[5], idx_i[0], idx_i[4:1]};
  assign q_o  = TBL[{~addr, 2'b11} -: 4];
endmodule

module sbox7 (
  input  logic [5:0] idx_i,
  output logic [3:0] q_o
);
  localparam logic [255:0] TBL = {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
                                  64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
  logic [5:0] addr;
  assign addr = {idx_i[5], idx_i[0], idx_i[4:1]};
  assign q_o  = TBL[{~addr, 2'b11} -: 4];
endmodule

module sbox8 (
  input  logic [5:0] idx_i,
  output logic [3:0] q_o
);
  localparam logic [255:0] TBL = {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
                                  64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};
  logic [5:0] addr;
  assign addr = {idx_i[5], idx_i[0], idx_i[4:1]};
  assign q_o  = TBL[{~addr, 2'b11} -: 4];
endmodule

module f_function_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] r_in,
  input  logic [47:0] subkey,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] f_out,
  output logic        busy
);

  logic [47:0] e_exp;
  logic [31:0] s_raw;
  logic [31:0] s_to_p;
  logic [31:0] p_out;

  logic        a_vld_q, a_vld_d;
  logic [47:0] a_x_q, a_x_d;
  logic        o_vld_q, o_vld_d;
  logic [31:0] o_f_q, o_f_d;

  logic        o_free;
  logic        a_adv;
  logic        o_load;
  logic        in_rdy_int;
  logic        in_acc;

  // Expansion written as its eight overlapping 6-bit groups, DES bit 32 wrapping to the front.
  assign e_exp = {r_in[0], r_in[31:27], r_in[28:23], r_in[24:19], r_in[20:15],
                  r_in[16:11], r_in[12:7], r_in[8:3], r_in[4:0], r_in[31]};

  sbox1 u_sbox1 (.idx_i(a_x_q[47:42]), .q_o(s_raw[31:28]));
  sbox2 u_sbox2 (.idx_i(a_x_q[41:36]), .q_o(s_raw[27:24]));
  sbox3 u_sbox3 (.idx_i(a_x_q[35:30]), .q_o(s_raw[23:20]));
  sbox4 u_sbox4 (.idx_i(a_x_q[29:24]), .q_o(s_raw[19:16]));
  sbox5 u_sbox5 (.idx_i(a_x_q[23:18]), .q_o(s_raw[15:12]));
  sbox6 u_sbox6 (.idx_i(a_x_q[17:12]), .q_o(s_raw[11:8]));
  sbox7 u_sbox7 (.idx_i(a_x_q[11:6]),  .q_o(s_raw[7:4]));
  sbox8 u_sbox8 (.idx_i(a_x_q[5:0]),   .q_o(s_raw[3:0]));

  assign o_free = !o_vld_q || out_ready;

`ifdef FFUNC_MID_REG_EN
  logic        b_vld_q, b_vld_d;
  logic [31:0] b_s_q, b_s_d;
  logic        b_adv;
  logic        b_free;

  assign b_free     = !b_vld_q || o_free;
  assign b_adv      = b_vld_q && o_free;
  assign a_adv      = a_vld_q && b_free;
  assign in_rdy_int = !a_vld_q || b_free;
  assign o_load     = b_adv;
  assign s_to_p     = b_s_q;
  assign busy       = a_vld_q || b_vld_q || o_vld_q;

  always_comb begin
    b_vld_d = b_vld_q;
    b_s_d   = b_s_q;
    if (a_adv) begin
      b_vld_d = 1'b1;
      b_s_d   = s_raw;
    end else if (b_adv) begin
      b_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_vld_q <= 1'b0;
      b_s_q   <= 32'h0;
    end else begin
      b_vld_q <= b_vld_d;
      b_s_q   <= b_s_d;
    end
  end
`else
  assign a_adv      = a_vld_q && o_free;
  assign in_rdy_int = !a_vld_q || o_free;
  assign o_load     = a_adv;
  assign s_to_p     = s_raw;
  assign busy       = a_vld_q || o_vld_q;
`endif

  assign p_out = {s_to_p[16], s_to_p[25], s_to_p[12], s_to_p[11],
                  s_to_p[3],  s_to_p[20], s_to_p[4],  s_to_p[15],
                  s_to_p[31], s_to_p[17], s_to_p[9],  s_to_p[6],
                  s_to_p[27], s_to_p[14], s_to_p[1],  s_to_p[22],
                  s_to_p[30], s_to_p[24], s_to_p[8],  s_to_p[18],
                  s_to_p[0],  s_to_p[5],  s_to_p[29], s_to_p[23],
                  s_to_p[13], s_to_p[19], s_to_p[2],  s_to_p[26],
                  s_to_p[10], s_to_p[21], s_to_p[28], s_to_p[7]};

  // Offers made while reset is held are acknowledged but never enter the pipe.
  assign in_acc   = in_valid && in_rdy_int;
  assign in_ready = in_rdy_int || !rst_n;

  always_comb begin
    a_vld_d = a_vld_q;
    a_x_d   = a_x_q;
    if (in_acc) begin
      a_vld_d = 1'b1;
      a_x_d   = e_exp ^ subkey;
    end else if (a_adv) begin
      a_vld_d = 1'b0;
    end
  end

  always_comb begin
    o_vld_d = o_vld_q;
    o_f_d   = o_f_q;
    if (o_load) begin
      o_vld_d = 1'b1;
      o_f_d   = p_out;
    end else if (out_ready) begin
      o_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_vld_q <= 1'b0;
      a_x_q   <= 48'h0;
      o_vld_q <= 1'b0;
      o_f_q   <= 32'h0;
    end else begin
      a_vld_q <= a_vld_d;
      a_x_q   <= a_x_d;
      o_vld_q <= o_vld_d;
      o_f_q   <= o_f_d;
    end
  end

  assign out_valid = o_vld_q;
  assign f_out     = o_f_q;

endmodule

// File: tb/tb_f_function_pipe.sv
// Bench for f_function_pipe: known-answer table, streaming, backpressure, mid-flight reset and
// random handshake traffic scored against a DES f-function model built from the standard tables.
module tb_f_function_pipe;

`ifdef FFUNC_MID_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] r_in;
  logic [47:0] subkey;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f_out;
  logic        busy;

  f_function_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .r_in     (r_in),
    .subkey   (subkey),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .f_out    (f_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int E_TBL [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
                     12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
                     22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  int P_TBL [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                     2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // DES numbers bits from 1 at the MSB, so DES bit n of a w-bit word is index w-n.
  function automatic logic [31:0] p_perm(input logic [31:0] s);
    logic [31:0] f;
    for (int i = 1; i <= 32; i++) f[32-i] = s[32-P_TBL[i-1]];
    return f;
  endfunction

  function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  six;
    int          row;
    int          col;
    for (int i = 1; i <= 48; i++) x[48-i] = r[32-E_TBL[i-1]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      row = 2 * int'(six[5]) + int'(six[0]);
      col = int'(six[4:1]);
      s[31-4*b -: 4] = 4'(SB[b][row*16 + col]);
    end
    return p_perm(s);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected results in acceptance order, popped on every output transfer.
  logic [31:0] exp_q[$];
  logic        held_vld = 1'b0;
  logic [31:0] held_dat = 32'h0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_data", f_out, held_dat);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %0h with no result outstanding", f_out);
        end else begin
          if (f_out !== exp_q[0]) begin
            errors++;
            $display("FAIL scoreboard_data: got %0h expected %0h", f_out, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      held_vld = out_valid && !out_ready;
      held_dat = f_out;
      if (in_valid && in_ready) exp_q.push_back(ref_f(r_in, subkey));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] r;
    logic [47:0] k;
    logic [31:0] f;
  } vec_t;
  vec_t vecs[5];

  int          lat;
  int          acc;
  int          run;
  int          gaps;
  int          irlow;
  int          saw;
  logic        first;
  logic        ir0;
  logic [31:0] held;

  initial begin
    vecs[0] = '{32'hF0AAF0AA, 48'h1B02EFFC7072, 32'h234AA9BB};
    vecs[1] = '{32'h0, 48'h0, p_perm(32'hEFA72C4D)};
    vecs[2] = '{32'hFFFFFFFF, 48'hFFFFFFFFFFFF, ref_f(32'hFFFFFFFF, 48'hFFFFFFFFFFFF)};
    vecs[3] = '{32'h12345678, 48'h0, ref_f(32'h12345678, 48'h0)};
    vecs[4] = '{32'h0, 48'hA5A5_5A5A_C3C3, ref_f(32'h0, 48'hA5A5_5A5A_C3C3)};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; r_in = '0; subkey = '0;
    @(posedge clk); #1;
    check("in_ready_during_reset", in_ready, 1);
    @(posedge clk); #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_f_out", f_out, 0);
    rst_n = 1'b1;
    #1 check("in_ready_after_reset", in_ready, 1);

    // Single known-answer transactions: latency and value.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      r_in = vecs[i].r; subkey = vecs[i].k; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, LAT);
      check($sformatf("vec%0d_f_out", i), f_out, vecs[i].f);
      @(posedge clk); #1;
    end

    // Back-to-back streaming with the sink always ready.
    first = 1'b0; run = 0; gaps = 0; irlow = 0;
    for (int c = 0; c < 100 + LAT + 4; c++) begin
      if (c < 100) begin
        in_valid = 1'b1; r_in = $urandom; subkey = {16'($urandom), 32'($urandom)};
      end else begin
        in_valid = 1'b0;
      end
      #1 if (c < 100 && !in_ready) irlow++;
      @(posedge clk); #1;
      if (out_valid) begin
        first = 1'b1;
        run++;
      end else if (first && run < 100) begin
        gaps++;
      end
    end
    check("stream_in_ready_drops", irlow, 0);
    check("stream_results", run, 100);
    check("stream_bubbles", gaps, 0);
    check("stream_drained", exp_q.size(), 0);

    // Backpressure: pipeline fills to capacity, then holds.
    out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; r_in = $urandom; subkey = {16'($urandom), 32'($urandom)};
      #1 if (in_ready) acc++;
      @(posedge clk); #1;
    end
    check("bp_accepts", acc, LAT);
    in_valid = 1'b0;
    #1 ir0 = in_ready;
    in_valid = 1'b1;
    #1;
    check("bp_in_ready_no_offer", ir0, 0);
    check("bp_in_ready_offer", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    held = f_out;
    repeat (5) @(posedge clk);
    #1 check("bp_f_out_stable", f_out, held);
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    check("bp_drained", exp_q.size(), 0);
    check("bp_busy_idle", busy, 0);

    // Reset with two results in flight.
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; r_in = $urandom; subkey = {16'($urandom), 32'($urandom)};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("mid_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_reset_out_valid", out_valid, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_f_out", f_out, 0);
    check("mid_reset_in_ready", in_ready, 1);
    rst_n = 1'b1; out_ready = 1'b1; saw = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) saw++;
    end
    check("mid_reset_no_stale", saw, 0);

    // Random valid/ready traffic; the scoreboard does the checking.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      r_in      = $urandom;
      subkey    = {16'($urandom), 32'($urandom)};
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    #1;
    check("rand_drained", exp_q.size(), 0);
    check("rand_busy_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
